// File: rtl/elevator_pkg.sv
// Shared types and constants for the 3-floor elevator scheduler.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 3;
    localparam int unsigned FLOOR_W    = 2;
    localparam int unsigned CNT_W      = 26;

    localparam logic [FLOOR_W-1:0] FLOOR_MIN = FLOOR_W'(0);
    localparam logic [FLOOR_W-1:0] FLOOR_MAX = FLOOR_W'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2,
        HALT   = 2'd3
    } state_t;

    // One-hot mask selecting a single floor.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/call_latch.sv
// Pending-request register with set/clear masks and direction summaries.
module call_latch
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] set_mask,
    input  logic [NUM_FLOORS-1:0] clr_mask,
    input  logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below
);

    // Clear wins over set so a served or suppressed floor never re-latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_mask) & ~clr_mask;
        end
    end

    // Summarise pending requests strictly above / below the current floor.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > floor)) begin
                any_above = 1'b1;
            end
            if (pending[i] && (FLOOR_W'(i) < floor)) begin
                any_below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Floor-request scheduler: SCAN direction choice, floor tracking and door timing.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DOOR_TIME = 50
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic                  move_clk,
    input  logic                  sos_mode,
    input  logic                  weight_limit_exceeded,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] req_led
);

    localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TIME - 1);

    state_t                state;
    state_t                state_next;
    logic [FLOOR_W-1:0]    floor_next;
    logic                  dir_next;
    logic [CNT_W-1:0]      door_cnt;
    logic [CNT_W-1:0]      door_cnt_next;
    logic                  move_clk_q;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] cur_oh;
    logic [NUM_FLOORS-1:0] next_oh;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  at_bound;
    logic                  any_above;
    logic                  any_below;
    logic                  here_call;
    logic                  eff_dir;

    call_latch u_call_latch (
        .clk       (clk),
        .reset     (reset),
        .set_mask  (call),
        .clr_mask  (clr_mask),
        .floor     (floor),
        .pending   (pending),
        .any_above (any_above),
        .any_below (any_below)
    );

    assign req_led    = pending;
    assign arrive     = move_clk & ~move_clk_q & (state == MOVING);
    assign cur_oh     = floor_onehot(floor);
    assign here_call  = |(call & cur_oh);
    assign at_bound   = dir_up ? (floor == FLOOR_MAX) : (floor == FLOOR_MIN);
    assign next_floor = dir_up ? (floor + FLOOR_W'(1)) : (floor - FLOOR_W'(1));
    assign next_oh    = floor_onehot(next_floor);

    // Direction as IDLE sees it: pinned at the end floors.
    always_comb begin
        eff_dir = dir_up;
        if (floor == FLOOR_MIN) begin
            eff_dir = 1'b1;
        end else if (floor == FLOOR_MAX) begin
            eff_dir = 1'b0;
        end
    end

    // Next-state, floor/direction, door counter and request-clear decode.
    always_comb begin
        state_next    = state;
        floor_next    = floor;
        dir_next      = dir_up;
        door_cnt_next = '0;
        clr_mask      = '0;

        // A call at the floor we stand at opens the door instead of latching.
        if (state == IDLE || state == DOOR) begin
            clr_mask = cur_oh;
        end

        if (sos_mode) begin
            state_next = HALT;
        end else begin
            case (state)
                IDLE: begin
                    dir_next = eff_dir;
                    if (here_call) begin
                        state_next = DOOR;
                    end else if (weight_limit_exceeded) begin
                        state_next = IDLE;
                    end else if (eff_dir ? any_above : any_below) begin
                        state_next = MOVING;
                    end else if (eff_dir ? any_below : any_above) begin
                        dir_next   = ~eff_dir;
                        state_next = MOVING;
                    end
                end
                MOVING: begin
                    if (arrive && !at_bound) begin
                        floor_next = next_floor;
                        if (|((pending | call) & next_oh)) begin
                            clr_mask   = next_oh;
                            state_next = DOOR;
                        end
                    end
                end
                DOOR: begin
                    if (here_call) begin
                        door_cnt_next = '0;
                    end else if (weight_limit_exceeded) begin
                        door_cnt_next = door_cnt;
                    end else if (door_cnt == DOOR_LAST) begin
                        state_next = IDLE;
                    end else begin
                        door_cnt_next = door_cnt + CNT_W'(1);
                    end
                end
                HALT: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            floor      <= FLOOR_MIN;
            dir_up     <= 1'b1;
            door_cnt   <= '0;
            move_clk_q <= 1'b0;
            moving     <= 1'b0;
            door_open  <= 1'b0;
        end else begin
            state      <= state_next;
            floor      <= floor_next;
            dir_up     <= dir_next;
            door_cnt   <= door_cnt_next;
            move_clk_q <= move_clk;
            moving     <= (state_next == MOVING);
            door_open  <= (state_next == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler against a behavioural model.
module tb_elevator_scheduler;

    localparam int unsigned DT = 5;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;
    localparam int M_HALT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] call;
    logic       move_clk;
    logic       sos_mode;
    logic       weight_limit_exceeded;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [2:0] req_led;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int       m_floor;
    bit       m_dir;
    bit [2:0] m_pend;
    int       m_mode;
    int       m_cnt;
    bit       m_mc_prev;

    elevator_scheduler #(.DOOR_TIME(DT)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .call                  (call),
        .move_clk              (move_clk),
        .sos_mode              (sos_mode),
        .weight_limit_exceeded (weight_limit_exceeded),
        .floor                 (floor),
        .dir_up                (dir_up),
        .moving                (moving),
        .door_open             (door_open),
        .req_led               (req_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend_toward(input bit up);
        for (int i = 0; i < 3; i++) begin
            if (m_pend[i] && (up ? (i > m_floor) : (i < m_floor))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_floor   = 0;
        m_dir     = 1'b1;
        m_pend    = 3'b000;
        m_mode    = M_IDLE;
        m_cnt     = 0;
        m_mc_prev = 1'b0;
    endfunction

    // One clock of the elevator, following the written rules directly.
    function automatic void model_step(input bit [2:0] c, input bit mc, input bit sos, input bit wt);
        bit [2:0] np = m_pend;
        bit rise = mc && !m_mc_prev;
        bit at_rest = (m_mode == M_IDLE) || (m_mode == M_DOOR);
        int tgt;
        for (int i = 0; i < 3; i++) begin
            if (c[i] && !(at_rest && i == m_floor)) np[i] = 1'b1;
        end
        if (at_rest) np[m_floor] = 1'b0;
        m_mc_prev = mc;
        if (sos) begin
            m_mode = M_HALT;
            m_cnt  = 0;
        end else if (m_mode == M_IDLE) begin
            if (m_floor == 0) m_dir = 1'b1;
            if (m_floor == 2) m_dir = 1'b0;
            if (c[m_floor]) begin
                m_mode = M_DOOR;
                m_cnt  = 0;
            end else if (!wt) begin
                if (pend_toward(m_dir)) begin
                    m_mode = M_MOVE;
                end else if (pend_toward(!m_dir)) begin
                    m_dir  = !m_dir;
                    m_mode = M_MOVE;
                end
            end
        end else if (m_mode == M_MOVE) begin
            tgt = m_dir ? m_floor + 1 : m_floor - 1;
            if (rise && tgt >= 0 && tgt <= 2) begin
                m_floor = tgt;
                if (m_pend[tgt] || c[tgt]) begin
                    np[tgt] = 1'b0;
                    m_mode  = M_DOOR;
                    m_cnt   = 0;
                end
            end
        end else if (m_mode == M_DOOR) begin
            if (c[m_floor]) m_cnt = 0;
            else if (wt) m_cnt = m_cnt;
            else if (m_cnt == int'(DT) - 1) m_mode = M_IDLE;
            else m_cnt = m_cnt + 1;
        end else begin
            m_mode = M_IDLE;
        end
        m_pend = np;
    endfunction

    task automatic compare_all();
        check("floor",     32'(floor),     32'(m_floor));
        check("dir_up",    32'(dir_up),    32'(m_dir));
        check("moving",    32'(moving),    32'(m_mode == M_MOVE));
        check("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
        check("req_led",   32'(req_led),   32'(m_pend));
    endtask

    task automatic step(input logic [2:0] c, input logic mc, input logic sos, input logic wt);
        call = c;
        move_clk = mc;
        sos_mode = sos;
        weight_limit_exceeded = wt;
        @(posedge clk);
        model_step(c, mc, sos, wt);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic run_until_door(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (door_open) break;
            step(3'b000, 1'b1, 1'b0, 1'b0);
            if (door_open) break;
            step(3'b000, 1'b0, 1'b0, 1'b0);
        end
        check(tag, 32'(door_open), 32'd1);
    endtask

    task automatic run_until_closed(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!door_open) break;
            step(3'b000, 1'b0, 1'b0, 1'b0);
        end
        check(tag, 32'(door_open), 32'd0);
    endtask

    initial begin
        int n;
        int sos_hold;
        int wt_hold;
        logic mc;
        logic [2:0] c;

        reset = 1'b1;
        call = 3'b000;
        move_clk = 1'b0;
        sos_mode = 1'b0;
        weight_limit_exceeded = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Reset, then idle
        repeat (10) step(3'b000, 1'b0, 1'b0, 1'b0);
        check("idle_floor", 32'(floor), 32'd0);
        check("idle_dir", 32'(dir_up), 32'd1);
        check("idle_led", 32'(req_led), 32'd0);

        // Call to floor 2 from floor 0, two floor edges
        step(3'b100, 1'b0, 1'b0, 1'b0);
        check("led_t1", 32'(req_led), 32'b100);
        check("mov_t1", 32'(moving), 32'd0);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("mov_t2", 32'(moving), 32'd1);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check("floor_e1", 32'(floor), 32'd1);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check("floor_e2", 32'(floor), 32'd2);
        check("door_e2", 32'(door_open), 32'd1);
        check("led_e2", 32'(req_led), 32'd0);
        check("mov_e2", 32'(moving), 32'd0);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            if (!door_open) break;
            n++;
        end
        check("door_len", 32'(n), 32'(DT));

        // Overload during door: counter frozen 20 cycles
        step(3'b100, 1'b0, 1'b0, 1'b0);
        n = door_open ? 1 : 0;
        repeat (20) begin
            step(3'b000, 1'b0, 1'b0, 1'b1);
            if (door_open) n++;
        end
        for (int i = 0; i < 100; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            if (!door_open) break;
            n++;
        end
        check("door_wt_len", 32'(n), 32'd25);

        // Overload in IDLE blocks departure
        step(3'b001, 1'b0, 1'b0, 1'b1);
        repeat (9) step(3'b000, 1'b0, 1'b0, 1'b1);
        check("wt_no_move", 32'(moving), 32'd0);
        check("wt_led", 32'(req_led), 32'b001);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("wt_release", 32'(moving), 32'd1);

        // SOS coincident with a floor edge mid-travel
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check("sos_pre_floor", 32'(floor), 32'd1);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b1, 1'b0);
        check("sos_floor", 32'(floor), 32'd1);
        check("sos_moving", 32'(moving), 32'd0);
        check("sos_led", 32'(req_led), 32'b001);
        repeat (3) step(3'b000, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("sos_idle", 32'(moving), 32'd0);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("sos_resume", 32'(moving), 32'd1);
        run_until_door("sos_door");
        check("sos_dest", 32'(floor), 32'd0);
        run_until_closed("sos_close");

        // SCAN: at floor 1 heading up with {0,2} pending
        step(3'b010, 1'b0, 1'b0, 1'b0);
        run_until_door("scan_f1");
        step(3'b101, 1'b0, 1'b0, 1'b0);
        check("scan_led", 32'(req_led), 32'b101);
        run_until_closed("scan_c1");
        run_until_door("scan_f2");
        check("scan_first", 32'(floor), 32'd2);
        run_until_closed("scan_c2");
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("scan_dir", 32'(dir_up), 32'd0);
        run_until_door("scan_f0");
        check("scan_second", 32'(floor), 32'd0);
        check("scan_led_end", 32'(req_led), 32'd0);
        run_until_closed("scan_c3");

        // Repeated current-floor calls hold the door
        step(3'b001, 1'b0, 1'b0, 1'b0);
        n = door_open ? 1 : 0;
        repeat (4) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            if (door_open) n++;
            step(3'b000, 1'b0, 1'b0, 1'b0);
            if (door_open) n++;
            step(3'b001, 1'b0, 1'b0, 1'b0);
            if (door_open) n++;
        end
        for (int i = 0; i < 100; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            if (!door_open) break;
            n++;
        end
        check("door_hold_len", 32'(n), 32'd17);

        // Randomized traffic with occasional SOS, overload and reset
        sos_hold = 0;
        wt_hold = 0;
        mc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sos_hold > 0) sos_hold--;
            else if ($urandom_range(0, 199) == 0) sos_hold = int'($urandom_range(1, 8));
            if (wt_hold > 0) wt_hold--;
            else if ($urandom_range(0, 99) == 0) wt_hold = int'($urandom_range(1, 30));
            if ($urandom_range(0, 2) == 0) mc = ~mc;
            c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(c, mc, sos_hold > 0, wt_hold > 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
